sme_job_sequencer: RTL and testbench

//  Front-end controller for the string-match engine (SME core). Captures the serial

---
 rtl/sme_pkg.sv | 21 ++
 rtl/sme_pat_queue.sv | 59 +++++
 rtl/sme_job_sequencer.sv | 145 ++++++++++++++
 tb/tb_sme_job_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared definitions for the string-match engine front end: character constants,
// default geometry, and the dispatch state encoding.
package sme_pkg;
    localparam int CHAR_W     = 8;
    localparam int STR_MAX    = 32;
    localparam int PAT_MAX    = 8;
    localparam int PAT_QDEPTH = 4;

    localparam logic [CHAR_W-1:0] CH_CARET  = 8'h5E;
    localparam logic [CHAR_W-1:0] CH_DOLLAR = 8'h24;
    localparam logic [CHAR_W-1:0] CH_DOT    = 8'h2E;
    localparam logic [CHAR_W-1:0] CH_STAR   = 8'h2A;
    localparam logic [CHAR_W-1:0] CH_SPACE  = 8'h20;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_START,
        DS_WAIT,
        DS_OUT
    } disp_state_e;
endpackage

// File: rtl/sme_pat_queue.sv
// Pattern slot FIFO: per-slot character RAM plus length/overflow tags.
// Characters are written straight into the tail slot; commit publishes it.
module sme_pat_queue
    import sme_pkg::*;
#(
    parameter int DEPTH = PAT_QDEPTH,
    parameter int PMAX  = PAT_MAX,
    localparam int AW   = $clog2(DEPTH),
    localparam int PIW  = $clog2(PMAX),
    localparam int LW   = $clog2(PMAX) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [PIW-1:0]    wr_idx_i,
    input  logic [CHAR_W-1:0] wr_char_i,
    input  logic              commit_i,
    input  logic [LW-1:0]     commit_len_i,
    input  logic              commit_ovf_i,
    input  logic              pop_i,
    input  logic [PIW-1:0]    rd_addr_i,
    output logic [CHAR_W-1:0] rd_char_o,
    output logic [LW-1:0]     head_len_o,
    output logic              head_ovf_o,
    output logic              full_o,
    output logic              empty_o
);
    logic [CHAR_W-1:0] mem_q [DEPTH][PMAX];
    logic [LW-1:0]     len_q [DEPTH];
    logic              ovf_q [DEPTH];
    logic [AW:0]       head_q, tail_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o    = (head_q == tail_q);
    assign full_o     = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
    assign rd_char_o  = mem_q[head_q[AW-1:0]][rd_addr_i];
    assign head_len_o = len_q[head_q[AW-1:0]];
    assign head_ovf_o = ovf_q[head_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                len_q[s] <= '0;
                ovf_q[s] <= 1'b0;
                for (int c = 0; c < PMAX; c++) mem_q[s][c] <= '0;
            end
        end else begin
            if (wr_en_i) mem_q[tail_q[AW-1:0]][wr_idx_i] <= wr_char_i;
            if (commit_i) begin
                len_q[tail_q[AW-1:0]] <= commit_len_i;
                ovf_q[tail_q[AW-1:0]] <= commit_ovf_i;
                tail_q                <= tail_q + 1'b1;
            end
            if (pop_i) head_q <= head_q + 1'b1;
        end
    end
endmodule

// File: rtl/sme_job_sequencer.sv
// Front-end controller for the SME core: buffers the string, queues patterns,
// dispatches them one at a time and re-times the engine result.
module sme_job_sequencer
    import sme_pkg::*;
#(
    parameter int STR_MAX_P    = STR_MAX,
    parameter int PAT_MAX_P    = PAT_MAX,
    parameter int PAT_QDEPTH_P = PAT_QDEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] chardata,
    input  logic              isstring,
    input  logic              ispattern,
    output logic              in_ready,
    output logic              eng_start,
    output logic [5:0]        eng_str_len,
    output logic [3:0]        eng_pat_len,
    input  logic [4:0]        eng_saddr,
    output logic [CHAR_W-1:0] eng_schar,
    input  logic [2:0]        eng_paddr,
    output logic [CHAR_W-1:0] eng_pchar,
    input  logic              eng_done,
    input  logic              eng_match,
    input  logic [4:0]        eng_index,
    output logic              valid,
    output logic              match,
    output logic [4:0]        match_index
);
    logic [CHAR_W-1:0] str_q [STR_MAX_P];
    logic [5:0]        str_len_q, str_idx;
    logic              str_run_q, in_burst_q, povf_q;
    logic [3:0]        pcnt_q;
    logic              str_acc, pat_beat, pat_acc, commit, pwr_en;
    logic [2:0]        pwr_idx;
    logic              q_full, q_empty, head_ovf;
    disp_state_e       state_q;
    logic              eng_start_q, valid_q, match_q;
    logic [4:0]        idx_q;

    always_comb begin
        pat_beat = ispattern & ~isstring;
        in_ready = 1'b1;
        // Hold string beats while any pattern is pending or being committed.
        if (isstring)
            in_ready = q_empty & (state_q == DS_IDLE) & ~in_burst_q;
        else if (pat_beat & ~in_burst_q)
            in_ready = ~q_full;
        str_acc = isstring & in_ready;
        pat_acc = pat_beat & in_ready;
        commit  = in_burst_q & ~pat_acc;
        str_idx = str_run_q ? str_len_q : 6'd0;
        pwr_en  = pat_acc & (~in_burst_q | (pcnt_q < 4'(PAT_MAX_P)));
        pwr_idx = in_burst_q ? pcnt_q[2:0] : 3'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            str_run_q  <= 1'b0;
            str_len_q  <= '0;
            in_burst_q <= 1'b0;
            pcnt_q     <= '0;
            povf_q     <= 1'b0;
            for (int i = 0; i < STR_MAX_P; i++) str_q[i] <= '0;
        end else begin
            str_run_q  <= str_acc;
            in_burst_q <= pat_acc;
            if (str_acc && (str_idx < 6'(STR_MAX_P))) begin
                str_q[str_idx[4:0]] <= chardata;
                str_len_q           <= str_idx + 6'd1;
            end
            if (pat_acc) begin
                if (!in_burst_q) begin
                    pcnt_q <= 4'd1;
                    povf_q <= 1'b0;
                end else if (pcnt_q < 4'(PAT_MAX_P)) begin
                    pcnt_q <= pcnt_q + 4'd1;
                end else begin
                    povf_q <= 1'b1;
                end
            end
        end
    end

    sme_pat_queue #(.DEPTH(PAT_QDEPTH_P), .PMAX(PAT_MAX_P)) u_queue (
        .clk          (clk),
        .reset        (reset),
        .wr_en_i      (pwr_en),
        .wr_idx_i     (pwr_idx),
        .wr_char_i    (chardata),
        .commit_i     (commit),
        .commit_len_i (pcnt_q),
        .commit_ovf_i (povf_q),
        .pop_i        (state_q == DS_OUT),
        .rd_addr_i    (eng_paddr),
        .rd_char_o    (eng_pchar),
        .head_len_o   (eng_pat_len),
        .head_ovf_o   (head_ovf),
        .full_o       (q_full),
        .empty_o      (q_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= DS_IDLE;
            eng_start_q <= 1'b0;
            valid_q     <= 1'b0;
            match_q     <= 1'b0;
            idx_q       <= '0;
        end else begin
            eng_start_q <= 1'b0;
            valid_q     <= 1'b0;
            case (state_q)
                DS_IDLE: if (!q_empty) begin
                    if (head_ovf) begin
                        // Overflowed pattern can never match; skip the engine.
                        state_q <= DS_OUT;
                        valid_q <= 1'b1;
                        match_q <= 1'b0;
                        idx_q   <= '0;
                    end else begin
                        state_q     <= DS_START;
                        eng_start_q <= 1'b1;
                    end
                end
                DS_START: state_q <= DS_WAIT;
                DS_WAIT: if (eng_done) begin
                    match_q <= eng_match;
                    idx_q   <= eng_index;
                    valid_q <= 1'b1;
                    state_q <= DS_OUT;
                end
                DS_OUT:  state_q <= DS_IDLE;
                default: state_q <= DS_IDLE;
            endcase
        end
    end

    assign eng_start   = eng_start_q;
    assign valid       = valid_q;
    assign match       = match_q;
    assign match_index = idx_q;
    assign eng_str_len = str_len_q;
    assign eng_schar   = str_q[eng_saddr];
endmodule

// File: tb/tb_sme_job_sequencer.sv
// Directed self-checking bench for sme_job_sequencer; the bench plays the engine.
module tb_sme_job_sequencer;
    logic       clk = 1'b0, reset = 1'b1;
    logic [7:0] chardata = '0;
    logic       isstring = 1'b0, ispattern = 1'b0;
    logic       in_ready, eng_start, valid, match;
    logic [5:0] eng_str_len;
    logic [3:0] eng_pat_len;
    logic [4:0] eng_saddr = '0, eng_index = '0, match_index;
    logic [7:0] eng_schar, eng_pchar;
    logic [2:0] eng_paddr = '0;
    logic       eng_done = 1'b0, eng_match = 1'b0;

    int n_checks = 0, n_fail = 0;
    int start_pend = 0, vcnt = 0, vbase;
    bit got;

    sme_job_sequencer dut (
        .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
        .ispattern(ispattern), .in_ready(in_ready), .eng_start(eng_start),
        .eng_str_len(eng_str_len), .eng_pat_len(eng_pat_len), .eng_saddr(eng_saddr),
        .eng_schar(eng_schar), .eng_paddr(eng_paddr), .eng_pchar(eng_pchar),
        .eng_done(eng_done), .eng_match(eng_match), .eng_index(eng_index),
        .valid(valid), .match(match), .match_index(match_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (eng_start) start_pend++;
        if (valid) vcnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] c, input logic s, input logic p);
        @(negedge clk);
        chardata = c; isstring = s; ispattern = p;
    endtask

    task automatic idle();
        beat(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) beat(s[i], 1'b1, 1'b0);
        idle();
    endtask

    task automatic send_pat(input string s);
        for (int i = 0; i < s.len(); i++) beat(s[i], 1'b0, 1'b1);
        idle();
    endtask

    task automatic wait_start(input string tag);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (start_pend > 0) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk(tag, got, 1'b1);
        if (got) start_pend--;
    endtask

    task automatic engine_done(input string tag, input logic m, input logic [4:0] ix);
        @(negedge clk);
        eng_done = 1'b1; eng_match = m; eng_index = ix;
        @(negedge clk);
        eng_done = 1'b0;
        chk({tag, "_valid"}, valid, 1'b1);
        chk({tag, "_match"}, match, m);
        chk({tag, "_index"}, match_index, ix);
        @(negedge clk);
        chk({tag, "_valid_pulse"}, valid, 1'b0);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", valid, 1'b0);
        chk("rst_start", eng_start, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_str_len", eng_str_len, 6'd0);
        reset = 1'b0;

        // 1: string "ab cd", pattern "cd"
        send_str("ab cd");
        send_pat("cd");
        wait_start("t1_start");
        chk("t1_str_len", eng_str_len, 6'd5);
        chk("t1_pat_len", eng_pat_len, 4'd2);
        eng_saddr = 5'd3; eng_paddr = 3'd1; #1;
        chk("t1_schar", eng_schar, 8'h63);
        chk("t1_pchar", eng_pchar, 8'h64);
        engine_done("t1", 1'b1, 5'd3);
        chk("t1_single_start", start_pend, 0);

        // 2: four patterns fill the queue, fifth burst stalls, results in order
        send_pat("ab"); send_pat("cd"); send_pat("ef"); send_pat("gh");
        beat("i", 1'b0, 1'b1); #1;
        chk("t2_full_ready", in_ready, 1'b0);
        beat("z", 1'b1, 1'b0); #1;
        chk("t2_str_blocked", in_ready, 1'b0);
        idle();
        eng_paddr = 3'd0;
        for (int i = 0; i < 4; i++) begin
            wait_start($sformatf("t2_start%0d", i));
            #1;
            chk($sformatf("t2_order%0d", i), eng_pchar, 8'h61 + 8'(2 * i));
            repeat (20) @(negedge clk);
            engine_done($sformatf("t2_res%0d", i), 1'(i & 1), 5'(i + 1));
        end
        chk("t2_str_len_kept", eng_str_len, 6'd5);

        // 3: 10-char pattern overflows -> no engine call, match=0
        vbase = vcnt;
        send_pat("0123456789");
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid) begin got = 1'b1; break; end
        end
        chk("t3_valid", got, 1'b1);
        chk("t3_match", match, 1'b0);
        chk("t3_pat_len", eng_pat_len, 4'd8);
        chk("t3_no_start", start_pend, 0);

        // 4: 40-char string saturates at 32
        for (int i = 0; i < 40; i++) beat(8'h41 + 8'(i), 1'b1, 1'b0);
        idle();
        chk("t4_str_len", eng_str_len, 6'd32);
        eng_saddr = 5'd31; #1;
        chk("t4_schar31", eng_schar, 8'h60);
        eng_saddr = 5'd0; #1;
        chk("t4_schar0", eng_schar, 8'h41);

        // 5: isstring and ispattern together -> string only
        vbase = vcnt;
        beat("x", 1'b1, 1'b1);
        idle();
        repeat (5) @(negedge clk);
        chk("t5_str_len", eng_str_len, 6'd1);
        chk("t5_schar", eng_schar, 8'h78);
        chk("t5_no_start", start_pend, 0);
        chk("t5_no_valid", vcnt - vbase, 0);

        // 6: reset while engine is busy
        send_pat("x");
        wait_start("t6_start");
        reset = 1'b1; #1;
        chk("t6_valid", valid, 1'b0);
        chk("t6_start_low", eng_start, 1'b0);
        chk("t6_str_len", eng_str_len, 6'd0);
        chk("t6_pat_len", eng_pat_len, 4'd0);
        vbase = vcnt;
        @(negedge clk);
        reset = 1'b0;
        eng_done = 1'b1; eng_match = 1'b1; eng_index = 5'd7;
        @(negedge clk);
        eng_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_stray_done", vcnt - vbase, 0);
        chk("t6_no_restart", start_pend, 0);
        chk("t6_match_clr", match, 1'b0);
        chk("t6_in_ready", in_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
